// File: rtl/mux_rr_n_1_v.sv
// N:1 valid/ready multiplexer with round-robin or fixed channel select
// and a registered output stage.
module mux_rr_n_1_v #(
  parameter int P_CHANNELS = 8,
  parameter int P_WIDTH    = 8,
  parameter int P_SEL_W    = $clog2(P_CHANNELS)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [P_CHANNELS-1:0]         i_valid,
  input  logic [P_CHANNELS*P_WIDTH-1:0] i_data,
  output logic [P_CHANNELS-1:0]         o_ready,
  input  logic                          i_mode,
  input  logic [P_SEL_W-1:0]            i_sel_code,
  output logic                          o_valid,
  output logic [P_WIDTH-1:0]            o_data,
  output logic [P_SEL_W-1:0]            o_sel_code,
  input  logic                          i_ready
);

  logic [P_SEL_W-1:0]    ptr;
  logic [P_SEL_W-1:0]    gnt_idx;
  logic [P_CHANNELS-1:0] elig;
  logic                  gnt_found;
  logic                  load;
  logic                  take;
  logic [P_WIDTH-1:0]    gnt_data;

  assign load = ~o_valid | i_ready;
  assign take = load & gnt_found;

  // Out-of-range select codes match no channel, so the set stays empty.
  always_comb begin
    elig = '0;
    for (int k = 0; k < P_CHANNELS; k++) begin
      if (i_mode)
        elig[k] = i_valid[k] & (i_sel_code == P_SEL_W'(k));
      else
        elig[k] = i_valid[k];
    end
  end

  // Winner is the eligible channel nearest after ptr, with wrap.
  always_comb begin : rr_search
    int best_d;
    int d;
    best_d    = P_CHANNELS;
    d         = 0;
    gnt_idx   = '0;
    gnt_found = |elig;
    for (int k = 0; k < P_CHANNELS; k++) begin
      d = (k + 2 * P_CHANNELS - int'(ptr) - 1) % P_CHANNELS;
      if (elig[k] && d < best_d) begin
        best_d  = d;
        gnt_idx = P_SEL_W'(k);
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < P_CHANNELS; k++) begin
      if (gnt_idx == P_SEL_W'(k))
        gnt_data = i_data[k*P_WIDTH +: P_WIDTH];
    end
  end

  always_comb begin
    o_ready = '0;
    for (int k = 0; k < P_CHANNELS; k++)
      o_ready[k] = take & i_rst_n & (gnt_idx == P_SEL_W'(k));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_sel_code <= '0;
      ptr        <= P_SEL_W'(P_CHANNELS - 1);
    end else if (take) begin
      o_valid    <= 1'b1;
      o_data     <= gnt_data;
      o_sel_code <= gnt_idx;
      ptr        <= gnt_idx;
    end else if (load) begin
      o_valid    <= 1'b0;
    end
  end

endmodule
